// File: rtl/bnb_pkg.sv
// Shared constants for the block/nonblock register-depth comparison pair.
package bnb_pkg;

  localparam int   BNB_MAX_DEPTH = 16;
  localparam logic BNB_RST_BIT   = 1'b0;

endpackage

// File: rtl/block.sv
// Collapsed register chain: every stage captures d on the same edge, so depth is always one.
module block
  import bnb_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH < 1 || DEPTH > BNB_MAX_DEPTH) begin : g_depth_check
    $error("block: DEPTH %0d outside 1..%0d", DEPTH, BNB_MAX_DEPTH);
  end

  logic [WIDTH-1:0] s [DEPTH];

  // Each stage sees the value just written to its predecessor, which is d itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) s[i] <= {WIDTH{BNB_RST_BIT}};
    end else begin
      for (int i = 0; i < DEPTH; i++) s[i] <= d;
    end
  end

  assign q = s[DEPTH-1];

endmodule

// File: rtl/nonblock.sv
// True DEPTH-stage shift register: every stage loads its predecessor's pre-edge value.
module nonblock
  import bnb_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH < 1 || DEPTH > BNB_MAX_DEPTH) begin : g_depth_check
    $error("nonblock: DEPTH %0d outside 1..%0d", DEPTH, BNB_MAX_DEPTH);
  end

  logic [WIDTH-1:0] s [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) s[i] <= {WIDTH{BNB_RST_BIT}};
    end else begin
      s[0] <= d;
      for (int i = 1; i < DEPTH; i++) s[i] <= s[i-1];
    end
  end

  assign q = s[DEPTH-1];

endmodule

// File: rtl/block_nonblock.sv
// Side-by-side pair: a true shift register and its collapsed single-stage counterpart.
module block_nonblock
  import bnb_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_nonblock,
  output logic [WIDTH-1:0] q_block
);

  nonblock #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_nonblock (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q_nonblock)
  );

  block #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_block (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q_block)
  );

endmodule

// File: tb/tb_block_nonblock.sv
// Scoreboard bench: four configurations share clk/rst; driver queues hand-computed results per edge.
module tb_block_nonblock;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d2  = 1'b0;
  logic [7:0] d4  = 8'h00;
  logic [7:0] d1  = 8'h00;
  logic [7:0] d3  = 8'h00;

  logic       qb2, qn2;
  logic [7:0] qb4, qn4, qb1, qn1, qb3, qn3;

  int tests  = 0;
  int failed = 0;
  bit drv_done = 1'b0;

  typedef struct {
    string      tag;
    logic       b2, n2;
    logic [7:0] b4, n4, b1, n1, b3, n3;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  block_nonblock #(.WIDTH(1), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .d(d2), .q_nonblock(qn2), .q_block(qb2));
  block_nonblock #(.WIDTH(8), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .d(d4), .q_nonblock(qn4), .q_block(qb4));
  block_nonblock #(.WIDTH(8), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .d(d1), .q_nonblock(qn1), .q_block(qb1));
  block_nonblock #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .d(d3), .q_nonblock(qn3), .q_block(qb3));

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " d2.q_block"},    {7'd0, qb2}, 8'h00);
    check({tag, " d2.q_nonblock"}, {7'd0, qn2}, 8'h00);
    check({tag, " d4.q_block"},    qb4, 8'h00);
    check({tag, " d4.q_nonblock"}, qn4, 8'h00);
    check({tag, " d1.q_block"},    qb1, 8'h00);
    check({tag, " d1.q_nonblock"}, qn1, 8'h00);
    check({tag, " d3.q_block"},    qb3, 8'h00);
    check({tag, " d3.q_nonblock"}, qn3, 8'h00);
  endtask

  // Drive on the falling edge, queue what the outputs must read after the next rising edge.
  task automatic step(input string tag, input logic r,
                      input logic v2, input logic [7:0] v4, input logic [7:0] v1, input logic [7:0] v3,
                      input logic eb2, input logic en2, input logic [7:0] eb4, input logic [7:0] en4,
                      input logic [7:0] eb1, input logic [7:0] en1, input logic [7:0] eb3, input logic [7:0] en3);
    exp_t e;
    @(negedge clk);
    rst = r; d2 = v2; d4 = v4; d1 = v1; d3 = v3;
    e.tag = tag;
    e.b2 = eb2; e.n2 = en2; e.b4 = eb4; e.n4 = en4;
    e.b1 = eb1; e.n1 = en1; e.b3 = eb3; e.n3 = en3;
    sb_q.push_back(e);
  endtask

  // Monitor: compare one queued expectation per rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check({e.tag, " d2.q_block"},    {7'd0, qb2}, {7'd0, e.b2});
        check({e.tag, " d2.q_nonblock"}, {7'd0, qn2}, {7'd0, e.n2});
        check({e.tag, " d4.q_block"},    qb4, e.b4);
        check({e.tag, " d4.q_nonblock"}, qn4, e.n4);
        check({e.tag, " d1.q_block"},    qb1, e.b1);
        check({e.tag, " d1.q_nonblock"}, qn1, e.n1);
        check({e.tag, " d3.q_block"},    qb3, e.b3);
        check({e.tag, " d3.q_nonblock"}, qn3, e.n3);
      end
    end
  end

  initial begin
    logic [7:0] v;
    // Reset asserted before the first edge, with nonzero inputs
    d2 = 1'b1; d4 = 8'hFF; d1 = 8'hFF; d3 = 8'hFF;
    #1 rst = 1'b1;
    #1 check_all_zero("reset_async_initial");
    for (int i = 0; i < 3; i++)
      step("reset_hold", 1, 1, 8'hFF, 8'hFF, 8'hFF, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    // Single pulse on the DEPTH=2 path
    step("pulse_e1", 0, 1, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("pulse_e2", 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("pulse_e3", 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    // Sequence 0,1,0,1,1,0 on the DEPTH=2 path
    step("seq_e1", 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("seq_e2", 0, 1, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("seq_e3", 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("seq_e4", 0, 1, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("seq_e5", 0, 1, 8'h00, 8'h00, 8'h00, 1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("seq_e6", 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("seq_e7", 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    // DEPTH=4, WIDTH=8 ramp
    step("d4_e1", 0, 0, 8'h11, 8'h00, 8'h00, 0, 0, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("d4_e2", 0, 0, 8'h22, 8'h00, 8'h00, 0, 0, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("d4_e3", 0, 0, 8'h33, 8'h00, 8'h00, 0, 0, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("d4_e4", 0, 0, 8'h44, 8'h00, 8'h00, 0, 0, 8'h44, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00);
    step("d4_e5", 0, 0, 8'h55, 8'h00, 8'h00, 0, 0, 8'h55, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00);
    step("d4_e6", 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00);
    step("d4_e7", 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00);
    step("d4_e8", 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00);
    step("d4_e9", 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    // DEPTH=1: both outputs equal the value sampled at the last edge
    for (int i = 0; i < 100; i++) begin
      v = 8'($urandom_range(0, 255));
      step("d1_rand", 0, 0, 8'h00, v, 8'h00, 0, 0, 8'h00, 8'h00, v, v, 8'h00, 8'h00);
    end

    // DEPTH=3: load data into every path, then reset mid-cycle
    step("mid_e1", 0, 1, 8'hC3, 8'h66, 8'hA5, 1, 0, 8'hC3, 8'h00, 8'h66, 8'h66, 8'hA5, 8'h00);
    step("mid_e2", 0, 1, 8'hC3, 8'h66, 8'h5A, 1, 1, 8'hC3, 8'h00, 8'h66, 8'h66, 8'h5A, 8'h00);
    step("mid_rst_edge", 0, 0, 8'h00, 8'h00, 8'h3C, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    #2 rst = 1'b1;
    #1 check_all_zero("reset_async_mid");
    step("mid_rst_hold", 1, 0, 8'h00, 8'h00, 8'h3C, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("post_e1", 0, 0, 8'h00, 8'h00, 8'h77, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h77, 8'h00);
    step("post_e2", 0, 0, 8'h00, 8'h00, 8'h88, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h88, 8'h00);
    step("post_e3", 0, 0, 8'h00, 8'h00, 8'h99, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h99, 8'h77);
    step("post_e4", 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h88);
    step("post_e5", 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h99);
    step("post_e6", 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    drv_done = 1'b1;
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(drv_done && sb_q.size() == 0) && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (2) @(posedge clk);
    #2;
    tests++;
    if (sb_q.size() != 0 || !drv_done) begin
      failed++;
      $display("FAIL drain: %0d expectations left, driver done=%0d, required 0 and 1", sb_q.size(), drv_done);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
